rx_frame_ctrl: RTL and testbench
================================

Name: rx_frame_ctrl

Overview:
Commit/drop controller for the RMII receive path. It buffers the 32-bit words produced by the aggregation stage for one frame, and waits for the checksum verdict (done/kill). It then either releases the frame to game logic over a valid/ready/last stream or discards it. It sits between the receive datapath outputs and the kart-state consumer, and it also keeps good and dropped frame counters.

Parameters:
DEPTH, 16, maximum buffered words per frame (power of two).
SETTLE, 8, cycles after done during which late aggregate words are still accepted.
TIMEOUT, 4096, idle cycles in COLLECT before the frame is abandoned.

Ports:
clk  in  1  50 MHz RMII reference clock
rstn  in  1  asynchronous active-low reset
axiiv  in  1  aggregated word valid (one-cycle pulses)
axiid  in  32  aggregated word
done  in  1  checksum verdict strobe (one cycle)
kill  in  1  checksum failed; sampled with done, or alone at any time
axior  in  1  downstream ready
axiov  out  1  output word valid
axiod  out  32  output word
axio_last  out  1  marks final word of the committed frame
busy  out  1  high in any state other than IDLE
good_count  out  16  committed frames, saturating
drop_count  out  16  dropped frames, saturating

Behaviour:
- Reset (asynchronous, rstn low): state=IDLE, wr_ptr=rd_ptr=0, all flags cleared, axiov=0, axio_last=0, axiod=0, busy=0, counters=0. Reset mid-frame or mid-drain discards everything with no counter update.
- States: IDLE, COLLECT, SETTLE_W, DRAIN, DROP.
- IDLE: axiiv -> write axiid at mem[0], wr_ptr=1, go to COLLECT. A done or kill arriving in IDLE is ignored.
- COLLECT:
  - Each axiiv writes mem[wr_ptr] and increments wr_ptr.
  - If wr_ptr==DEPTH and axiiv arrives, the word is discarded and the sticky ovf flag is set.
  - done with kill=0 -> SETTLE_W, settle counter=0.
  - kill (with or without done) -> DROP.
  - TIMEOUT consecutive cycles with no axiiv and no done -> DROP.
  - Priority when events coincide: kill > done > timeout. A word with axiiv in the same cycle as done is still stored.
- SETTLE_W:
  - Keeps accepting words under the same overflow rule.
  - kill -> DROP.
  - After SETTLE cycles: if ovf or wr_ptr==0 go to DROP, otherwise go to DRAIN with rd_ptr=0.
- DRAIN:
  - axiov=1, axiod=mem[rd_ptr], axio_last=(rd_ptr==wr_ptr-1).
  - axiod is held stable while axior=0.
  - When axiov&axior: rd_ptr increments. On the last word, good_count increments (saturating at 0xFFFF), pointers clear and state returns to IDLE. axiov drops in the following cycle.
  - axiiv in DRAIN is discarded and does not start a new frame.
- DROP: lasts one cycle. drop_count increments (saturating), pointers and ovf clear, then IDLE. axiiv in DROP is discarded.
- Output is registered. The first DRAIN word appears on the cycle the state becomes DRAIN, i.e. SETTLE+1 cycles after done.
- Pointer widths are $clog2(DEPTH)+1 bits, so a full buffer is distinct from an empty one. No wrap-around within a frame.
- busy=1 in every state except IDLE.

Decomposition:
- Package rx_ctrl_pkg:
  - state_t enum (IDLE, COLLECT, SETTLE_W, DRAIN, DROP)
  - WORD_W=32
  - CNT_W=16
  - saturating-increment function
- Sub-module rx_frame_buf: a DEPTH x 32 simple dual-port memory, with synchronous write and combinational read into the registered axiod stage.

Test Plan:
- Good frame: 5 words 0x11111111..0x55555555, then done=1/kill=0 -> after 9 cycles axiov=1. The 5 words come out in order, axio_last on 0x55555555, good_count=1, drop_count=0.
- Bad CRC: 4 words, then done=1 with kill=1 -> no axiov, drop_count=1, state IDLE next cycle.
- Backpressure: 3-word good frame with axior toggling 1,0,0,1,0,1 -> each word is held stable while axior=0 and transfers exactly once; axio_last only on the 3rd word.
- Overflow: 17 words with DEPTH=16, then done/kill=0 -> frame dropped, drop_count=1. A following 2-word good frame commits normally, good_count=1.
- Timeout and late words:
  - 2 words with no done for 4096 cycles -> drop_count=1.
  - Separately, done followed 3 cycles later by a final word -> that word is included in DRAIN.
- Reset: rstn low for 1 cycle during DRAIN of word 2 -> axiov=0 immediately, counters=0. The next good frame commits from word 0.

Source files
------------

// File: rtl/rx_frame_ctrl_pkg.sv
// Shared types and helpers for the RMII receive commit/drop controller.
//   state_t  : controller state encoding
//   WORD_W   : aggregated word width
//   CNT_W    : frame counter width
//   sat_inc  : saturating increment used by the good/drop counters
package rx_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SETTLE_W,
        DRAIN,
        DROP
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Stream bundle around the frame controller.
//   upstream  : axiiv/axiid (aggregated words), done/kill (checksum verdict)
//   downstream: axiov/axiod/axio_last (committed frame), axior (ready)
// slave  = the controller, master = whoever drives the receive side and
// consumes the committed stream.
interface rx_frame_ctrl_if;
    import rx_ctrl_pkg::*;

    logic              axiiv;
    logic [WORD_W-1:0] axiid;
    logic              done;
    logic              kill;
    logic              axior;
    logic              axiov;
    logic [WORD_W-1:0] axiod;
    logic              axio_last;

    modport master (output axiiv, axiid, done, kill, axior,
                    input  axiov, axiod, axio_last);
    modport slave  (input  axiiv, axiid, done, kill, axior,
                    output axiov, axiod, axio_last);
endinterface

// File: rtl/rx_frame_buf.sv
// Single-frame word buffer: DEPTH x WORD_W simple dual-port memory.
//   clk          : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : combinational read port (registered by the controller)
module rx_frame_buf
    import rx_ctrl_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_frame_ctrl.sv
// Commit/drop controller for the RMII receive path. Buffers one frame of
// aggregated words, waits for the checksum verdict, then either streams the
// frame out (valid/ready/last) or discards it, counting both outcomes.
//   clk, rstn   : clock, asynchronous active-low reset
//   bus (slave) : upstream words + verdict in, committed stream out
//   busy        : controller not in IDLE
//   good_count  : committed frames (saturating)
//   drop_count  : dropped frames (saturating)
module rx_frame_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rstn,
    rx_frame_ctrl_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;              // extra bit: full != empty
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t            state;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              ovf;
    logic [SW-1:0]     settle_cnt;
    logic [TW-1:0]     idle_cnt;

    logic              filling, full, we;
    logic [PW-1:0]     wr_nxt, rd_nxt;
    logic              ovf_nxt;
    logic [AW-1:0]     raddr;
    logic [WORD_W-1:0] rdata;

    assign filling = (state == COLLECT) || (state == SETTLE_W);
    assign full    = (wr_ptr == PW'(DEPTH));
    // IDLE always writes slot 0 (wr_ptr is cleared there).
    assign we      = bus.axiiv && ((state == IDLE) || (filling && !full));
    assign wr_nxt  = wr_ptr + PW'(we);
    assign ovf_nxt = ovf || (bus.axiiv && filling && full);
    assign rd_nxt  = rd_ptr + PW'(1);
    // Look one word ahead in DRAIN so axiod can load on the handshake edge;
    // elsewhere slot 0 is presented for the DRAIN entry load.
    assign raddr   = (state == DRAIN) ? rd_nxt[AW-1:0] : '0;
    assign busy    = (state != IDLE);

    rx_frame_buf #(.DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.axiid),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ovf           <= 1'b0;
            settle_cnt    <= '0;
            idle_cnt      <= '0;
            bus.axiov     <= 1'b0;
            bus.axiod     <= '0;
            bus.axio_last <= 1'b0;
            good_count    <= '0;
            drop_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.axiiv) begin
                        wr_ptr   <= PW'(1);
                        ovf      <= 1'b0;
                        idle_cnt <= '0;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    wr_ptr <= wr_nxt;
                    ovf    <= ovf_nxt;
                    if (bus.kill) begin
                        state <= DROP;
                    end else if (bus.done) begin
                        settle_cnt <= '0;
                        state      <= SETTLE_W;
                    end else if (bus.axiiv) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                        state <= DROP;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                SETTLE_W: begin
                    wr_ptr <= wr_nxt;
                    ovf    <= ovf_nxt;
                    if (bus.kill) begin
                        state <= DROP;
                    end else if (settle_cnt == SW'(SETTLE)) begin
                        // Decide on the post-write view so a word landing on
                        // this final edge is counted.
                        if (ovf_nxt || wr_nxt == '0) begin
                            state <= DROP;
                        end else begin
                            rd_ptr        <= '0;
                            bus.axiov     <= 1'b1;
                            bus.axiod     <= rdata;
                            bus.axio_last <= (wr_nxt == PW'(1));
                            state         <= DRAIN;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                DRAIN: begin
                    if (bus.axiov && bus.axior) begin
                        if (bus.axio_last) begin
                            good_count    <= sat_inc(good_count);
                            wr_ptr        <= '0;
                            rd_ptr        <= '0;
                            bus.axiov     <= 1'b0;
                            bus.axio_last <= 1'b0;
                            bus.axiod     <= '0;
                            state         <= IDLE;
                        end else begin
                            rd_ptr        <= rd_nxt;
                            bus.axiod     <= rdata;
                            bus.axio_last <= (rd_nxt == wr_ptr - PW'(1));
                        end
                    end
                end
                DROP: begin
                    drop_count <= sat_inc(drop_count);
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    ovf        <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: frame-level reference model
// (expected output word queue + expected counters) with a per-cycle stream
// compare process, directed scenarios and randomized frames.
module tb_rx_frame_ctrl;
    import rx_ctrl_pkg::*;

    localparam int DEPTH   = 16;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        busy;
    logic [15:0] good_count, drop_count;

    always #10 clk = ~clk;

    rx_frame_ctrl_if bus ();

    rx_frame_ctrl #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .busy       (busy),
        .good_count (good_count),
        .drop_count (drop_count)
    );

    int checks = 0;
    int fails  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: words the committed frame must deliver, and counters.
    logic [31:0] exp_q[$];
    int          exp_good = 0;
    int          exp_drop = 0;

    // Ready generator: 0 always ready, 1 random, 2 pattern while valid.
    int   rdy_mode = 0;
    logic pat[6];
    int   pidx = 0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: bus.axior = 1'($urandom_range(0, 1));
            2: begin
                if (bus.axiov) begin
                    bus.axior = (pidx < 6) ? pat[pidx] : 1'b1;
                    pidx++;
                end else begin
                    bus.axior = 1'b1;
                end
            end
            default: bus.axior = 1'b1;
        endcase
    end

    // Stream compare: data/last against model head, hold under backpressure,
    // no valid without an expected word.
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [31:0] prev_d = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_v = 1'b0;
        end else begin
            if (exp_q.size() == 0) begin
                chk("valid_without_frame", bus.axiov, 0);
            end else if (bus.axiov) begin
                chk("axiod", bus.axiod, exp_q[0]);
                chk("axio_last", bus.axio_last, (exp_q.size() == 1));
                if (bus.axior) void'(exp_q.pop_front());
            end
            if (prev_v && !prev_r) begin
                chk("hold_valid", bus.axiov, 1);
                chk("hold_data", bus.axiod, prev_d);
            end
            prev_v = bus.axiov;
            prev_r = bus.axior;
            prev_d = bus.axiod;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bus.axiiv = 1'b1;
        bus.axiid = w;
        cyc();
        bus.axiiv = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            cyc();
            n++;
        end
        chk("frame_finished", busy, 0);
        chk("all_words_out", exp_q.size(), 0);
        chk("good_count", good_count, exp_good);
        chk("drop_count", drop_count, exp_drop);
    endtask

    // nw words total, the last `late` of them sent after done.
    // kmode: 0 done only, 1 done+kill, 2 kill alone in collect, 3 kill in settle.
    // Word i = base*(i+1) when base != 0, else random.
    task automatic run_frame(input int nw, input int late, input int kmode,
                             input int gapmax, input int late_gap,
                             input logic [31:0] base);
        logic [31:0] ws[$];
        int e;
        bit commit;
        for (int i = 0; i < nw; i++)
            ws.push_back((base != 0) ? base * (i + 1) : $urandom);
        for (int i = 0; i < nw - late; i++) begin
            send_word(ws[i]);
            repeat ($urandom_range(0, gapmax)) cyc();
        end
        if (kmode == 2) begin
            bus.kill = 1'b1;
            cyc();
            bus.kill = 1'b0;
            exp_drop++;
            return;
        end
        commit = (kmode == 0) && (nw <= DEPTH);
        if (commit) foreach (ws[i]) exp_q.push_back(ws[i]);
        else exp_drop++;
        bus.done = 1'b1;
        bus.kill = (kmode == 1);
        cyc();
        bus.done = 1'b0;
        bus.kill = 1'b0;
        e = 0;
        for (int i = nw - late; i < nw; i++) begin
            int g = (late_gap >= 0) ? late_gap : int'($urandom_range(0, 1));
            repeat (g) begin cyc(); e++; end
            send_word(ws[i]);
            e++;
        end
        if (kmode == 3) begin
            bus.kill = 1'b1;
            cyc();
            bus.kill = 1'b0;
            e++;
        end
        if (commit) begin
            exp_good++;
            while (!bus.axiov && e < 40) begin cyc(); e++; end
            chk("first_valid_latency", e, SETTLE + 1);
            if (base != 0) chk("first_word_literal", bus.axiod, base);
        end
    endtask

    initial begin
        bus.axiiv = 1'b0;
        bus.axiid = '0;
        bus.done  = 1'b0;
        bus.kill  = 1'b0;

        // Reset state
        #5;
        chk("rst_axiov", bus.axiov, 0);
        chk("rst_axio_last", bus.axio_last, 0);
        chk("rst_axiod", bus.axiod, 0);
        chk("rst_busy", busy, 0);
        chk("rst_good", good_count, 0);
        chk("rst_drop", drop_count, 0);
        cyc(); cyc();
        rstn = 1'b1;
        cyc();

        // Verdict strobes in IDLE are ignored
        bus.done = 1'b1; bus.kill = 1'b1;
        cyc();
        bus.done = 1'b0; bus.kill = 1'b0;
        chk("idle_verdict_ignored", busy, 0);
        wait_idle();

        // Good frame 0x11111111..0x55555555
        run_frame(5, 0, 0, 0, -1, 32'h1111_1111);
        wait_idle();
        chk("good_frame_good_lit", good_count, 1);
        chk("good_frame_drop_lit", drop_count, 0);

        // Bad CRC: dropped, DROP lasts one cycle, a word in DROP is discarded
        for (int i = 0; i < 4; i++) send_word(32'hA000_0000 + i);
        bus.done = 1'b1; bus.kill = 1'b1;
        cyc();
        bus.done = 1'b0; bus.kill = 1'b0;
        chk("drop_state_busy", busy, 1);
        send_word(32'hBAD0_0001);
        chk("idle_after_drop", busy, 0);
        chk("bad_crc_drop_lit", drop_count, 1);
        exp_drop++;
        wait_idle();

        // Backpressure 1,0,0,1,0,1; a word arriving in DRAIN is discarded
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        pidx = 0;
        rdy_mode = 2;
        run_frame(3, 0, 0, 1, -1, 32'h0C0C_0C0C);
        send_word(32'hDEAD_BEEF);
        wait_idle();
        rdy_mode = 0;

        // Overflow: 17 words dropped, then a 2-word frame commits
        run_frame(DEPTH + 1, 0, 0, 0, -1, 32'h0000_0101);
        wait_idle();
        run_frame(2, 0, 0, 0, -1, 32'h0202_0000);
        wait_idle();

        // Late word 3 cycles after done is part of the frame
        run_frame(4, 1, 0, 0, 2, 32'h0033_0000);
        wait_idle();

        // Timeout: 2 words then silence
        send_word(32'h7777_0001);
        send_word(32'h7777_0002);
        repeat (TIMEOUT) cyc();
        chk("timeout_still_busy", busy, 1);
        chk("timeout_not_yet", drop_count, exp_drop);
        cyc();
        exp_drop++;
        chk("timeout_drop", drop_count, exp_drop);
        chk("timeout_idle", busy, 0);

        // Reset while word 2 is being held in DRAIN
        pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        pidx = 0;
        rdy_mode = 2;
        run_frame(4, 0, 0, 0, -1, 32'h0505_0505);
        cyc(); cyc();
        chk("held_word2", bus.axiod, 32'h0A0A_0A0A);
        rstn = 1'b0;
        #1;
        chk("rst_mid_axiov", bus.axiov, 0);
        chk("rst_mid_good", good_count, 0);
        chk("rst_mid_drop", drop_count, 0);
        chk("rst_mid_busy", busy, 0);
        exp_q.delete();
        exp_good = 0;
        exp_drop = 0;
        rdy_mode = 0;
        cyc();
        rstn = 1'b1;
        cyc();
        run_frame(3, 0, 0, 0, -1, 32'h0606_0000);
        wait_idle();
        chk("post_reset_good_lit", good_count, 1);

        // Randomized frames with random backpressure
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int nw   = $urandom_range(1, DEPTH + 2);
            int late = $urandom_range(0, 3);
            int r    = $urandom_range(0, 9);
            int km   = (r < 6) ? 0 : (r - 6);
            if (late > nw - 1) late = nw - 1;
            run_frame(nw, late, km, 2, -1, 32'h0);
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
